// File: rtl/xif_offload_ctrl.sv
// xif_offload_ctrl: core-side CV-X-IF initiator. Takes one custom instruction
// from ID and runs it through issue -> commit -> result, then drives a
// one-cycle writeback strobe (or an illegal pulse if the coprocessor rejects).
// One instruction in flight at a time.
// Optional build macro XIF_TIMEOUT_EN: enables a result watchdog that abandons
// the RESULT wait after TIMEOUT_CYCLES cycles and pulses timeout_o.
module xif_offload_ctrl #(
  parameter int X_ID_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  id_valid_i,
  output logic                  id_ready_o,
  input  logic [31:0]           id_instr_i,
  input  logic [31:0]           id_rs1_i,
  input  logic [31:0]           id_rs2_i,
  input  logic                  id_kill_i,
  output logic                  xif_issue_valid_o,
  input  logic                  xif_issue_ready_i,
  output logic [31:0]           xif_issue_instr_o,
  output logic [31:0]           xif_issue_rs1_o,
  output logic [31:0]           xif_issue_rs2_o,
  output logic [X_ID_WIDTH-1:0] xif_issue_id_o,
  input  logic                  xif_issue_accept_i,
  output logic                  xif_commit_valid_o,
  output logic [X_ID_WIDTH-1:0] xif_commit_id_o,
  output logic                  xif_commit_kill_o,
  input  logic                  xif_result_valid_i,
  output logic                  xif_result_ready_o,
  input  logic [X_ID_WIDTH-1:0] xif_result_id_i,
  input  logic [4:0]            xif_result_rd_i,
  input  logic                  xif_result_we_i,
  input  logic [31:0]           xif_result_data_i,
  output logic                  wb_valid_o,
  output logic [4:0]            wb_rd_o,
  output logic [31:0]           wb_data_o,
  output logic                  illegal_o,
  output logic                  busy_o,
  output logic                  timeout_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } iss_req_t;

  logic [1:0]            state_q, state_d;
  iss_req_t              req_q, req_d;
  logic [X_ID_WIDTH-1:0] id_cnt_q, id_cnt_d;
  logic [X_ID_WIDTH-1:0] iss_id_q, iss_id_d;
  logic                  kill_pend_q, kill_pend_d;
  logic                  illegal_q, illegal_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [4:0]            wb_rd_q, wb_rd_d;
  logic [31:0]           wb_data_q, wb_data_d;
  logic                  timeout_q, timeout_d;

  logic issue_hs, res_match, commit_kill, tmo_hit;

  assign issue_hs    = (state_q == S_ISSUE) && xif_issue_ready_i;
  assign res_match   = (state_q == S_RESULT) && xif_result_valid_i &&
                       (xif_result_id_i == iss_id_q);
  // A kill seen in the commit cycle itself still has to reach the coprocessor.
  assign commit_kill = kill_pend_q || id_kill_i;

`ifdef XIF_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (state_q == S_RESULT) && !res_match &&
                   (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog: restart while committing, count every RESULT cycle without a match.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == S_COMMIT)                     tmo_cnt_d = '0;
    else if (state_q == S_RESULT && !res_match)  tmo_cnt_d = tmo_cnt_q + TW'(1);
  end

  // Watchdog counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tmo_cnt_q <= '0;
    else         tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
  assign tmo_hit    = 1'b0;
`endif

  // Next-state: IDLE -> ISSUE -> COMMIT -> RESULT -> IDLE with early exits.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (id_valid_i && !id_kill_i) state_d = S_ISSUE;
      S_ISSUE:  if (issue_hs) state_d = xif_issue_accept_i ? S_COMMIT : S_IDLE;
      S_COMMIT: state_d = commit_kill ? S_IDLE : S_RESULT;
      S_RESULT: if (res_match || tmo_hit) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: payload capture, ID counter, kill tracking, strobes.
  always_comb begin
    req_d = req_q;
    if (state_q == S_IDLE && id_valid_i && !id_kill_i)
      req_d = '{instr: id_instr_i, rs1: id_rs1_i, rs2: id_rs2_i};

    // Every issue handshake consumes an ID, accepted or not.
    id_cnt_d = issue_hs ? id_cnt_q + X_ID_WIDTH'(1) : id_cnt_q;
    iss_id_d = issue_hs ? id_cnt_q : iss_id_q;

    kill_pend_d = kill_pend_q;
    if ((state_q == S_ISSUE || state_q == S_COMMIT) && id_kill_i) kill_pend_d = 1'b1;
    if (state_d == S_IDLE) kill_pend_d = 1'b0;

    illegal_d  = issue_hs && !xif_issue_accept_i;
    wb_valid_d = res_match && xif_result_we_i;
    wb_rd_d    = res_match ? xif_result_rd_i   : wb_rd_q;
    wb_data_d  = res_match ? xif_result_data_i : wb_data_q;
    timeout_d  = tmo_hit;
  end

  // State and payload registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      id_cnt_q    <= '0;
      iss_id_q    <= '0;
      kill_pend_q <= 1'b0;
      illegal_q   <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      id_cnt_q    <= id_cnt_d;
      iss_id_q    <= iss_id_d;
      kill_pend_q <= kill_pend_d;
      illegal_q   <= illegal_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      timeout_q   <= timeout_d;
    end
  end

  assign id_ready_o         = (state_q == S_IDLE);
  assign busy_o             = (state_q != S_IDLE);
  assign xif_issue_valid_o  = (state_q == S_ISSUE);
  assign xif_issue_instr_o  = req_q.instr;
  assign xif_issue_rs1_o    = req_q.rs1;
  assign xif_issue_rs2_o    = req_q.rs2;
  assign xif_issue_id_o     = id_cnt_q;
  assign xif_commit_valid_o = (state_q == S_COMMIT);
  assign xif_commit_id_o    = iss_id_q;
  assign xif_commit_kill_o  = (state_q == S_COMMIT) && commit_kill;
  assign xif_result_ready_o = (state_q == S_RESULT);
  assign wb_valid_o         = wb_valid_q;
  assign wb_rd_o            = wb_rd_q;
  assign wb_data_o          = wb_data_q;
  assign illegal_o          = illegal_q;
  assign timeout_o          = timeout_q;

endmodule

// File: tb/tb_xif_offload_ctrl.sv
// Scoreboard bench for xif_offload_ctrl: stimulus pushes expected commit,
// writeback and illegal events; a negedge monitor pops and compares them.
module tb_xif_offload_ctrl;
  localparam int XW = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          id_valid_i = 0, id_kill_i = 0;
  logic [31:0]   id_instr_i = 0, id_rs1_i = 0, id_rs2_i = 0;
  logic          xif_issue_ready_i = 0, xif_issue_accept_i = 0;
  logic          xif_result_valid_i = 0, xif_result_we_i = 0;
  logic [XW-1:0] xif_result_id_i = 0;
  logic [4:0]    xif_result_rd_i = 0;
  logic [31:0]   xif_result_data_i = 0;

  logic          id_ready_o, xif_issue_valid_o, xif_commit_valid_o, xif_commit_kill_o;
  logic [31:0]   xif_issue_instr_o, xif_issue_rs1_o, xif_issue_rs2_o, wb_data_o;
  logic [XW-1:0] xif_issue_id_o, xif_commit_id_o;
  logic          xif_result_ready_o, wb_valid_o, illegal_o, busy_o, timeout_o;
  logic [4:0]    wb_rd_o;

  xif_offload_ctrl #(.X_ID_WIDTH(XW), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .id_instr_i(id_instr_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_kill_i(id_kill_i),
    .xif_issue_valid_o(xif_issue_valid_o), .xif_issue_ready_i(xif_issue_ready_i),
    .xif_issue_instr_o(xif_issue_instr_o), .xif_issue_rs1_o(xif_issue_rs1_o),
    .xif_issue_rs2_o(xif_issue_rs2_o), .xif_issue_id_o(xif_issue_id_o),
    .xif_issue_accept_i(xif_issue_accept_i),
    .xif_commit_valid_o(xif_commit_valid_o), .xif_commit_id_o(xif_commit_id_o),
    .xif_commit_kill_o(xif_commit_kill_o),
    .xif_result_valid_i(xif_result_valid_i), .xif_result_ready_o(xif_result_ready_o),
    .xif_result_id_i(xif_result_id_i), .xif_result_rd_i(xif_result_rd_i),
    .xif_result_we_i(xif_result_we_i), .xif_result_data_i(xif_result_data_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .illegal_o(illegal_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [XW-1:0] id; logic kill; } cmt_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;
  cmt_t cmt_q[$];
  wb_t  wb_q[$];
  int   ill_q[$];
  int   tmo_q[$];

  int n_run = 0, n_fail = 0;
  logic [XW-1:0] exp_id = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    n_run++;
    n_fail++;
    $display("FAIL %s: strobe with nothing expected", nm);
  endtask

  // Monitor: every strobe must match the head of its expectation queue.
  cmt_t mc;
  wb_t  mw;
  always @(negedge clk) begin
    if (rst_n) begin
      if (xif_commit_valid_o) begin
        if (cmt_q.size() == 0) unexpected("commit");
        else begin
          mc = cmt_q.pop_front();
          chk("commit_id", xif_commit_id_o, mc.id);
          chk("commit_kill", xif_commit_kill_o, mc.kill);
        end
      end
      if (wb_valid_o) begin
        if (wb_q.size() == 0) unexpected("wb_valid");
        else begin
          mw = wb_q.pop_front();
          chk("wb_rd", wb_rd_o, mw.rd);
          chk("wb_data", wb_data_o, mw.data);
        end
      end
      if (illegal_o) begin
        if (ill_q.size() == 0) unexpected("illegal");
        else void'(ill_q.pop_front());
      end
      if (timeout_o) begin
        if (tmo_q.size() == 0) unexpected("timeout");
        else void'(tmo_q.pop_front());
      end
      if (illegal_o && wb_valid_o) unexpected("illegal_and_wb");
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One instruction end to end; bp = cycles of issue backpressure.
  task automatic run_op(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                        input int bp, input bit acc, input bit kill_iss, input int n_wrong,
                        input logic [4:0] rd, input logic [31:0] dat, input bit we,
                        input bit kill_res);
    logic [XW-1:0] iss;
    int w;
    w = 0;
    while (!id_ready_o && w < 20) begin step(); w++; end
    chk("id_ready", id_ready_o, 1);
    iss = exp_id;
    if (!acc) ill_q.push_back(1);
    else begin
      cmt_q.push_back(cmt_t'{id: iss, kill: kill_iss});
      if (!kill_iss && we) wb_q.push_back(wb_t'{rd: rd, data: dat});
    end
    id_valid_i = 1; id_instr_i = ins; id_rs1_i = r1; id_rs2_i = r2;
    step();
    // Scramble ID inputs: the issued payload must come from the latch.
    id_valid_i = 0; id_instr_i = ~ins; id_rs1_i = ~r1; id_rs2_i = ~r2;
    id_kill_i = kill_iss;
    for (int c = 0; c <= bp; c++) begin
      chk("iss_valid", xif_issue_valid_o, 1);
      chk("iss_instr", xif_issue_instr_o, ins);
      chk("iss_rs1", xif_issue_rs1_o, r1);
      chk("iss_rs2", xif_issue_rs2_o, r2);
      chk("iss_id", xif_issue_id_o, iss);
      if (c == bp) begin xif_issue_ready_i = 1; xif_issue_accept_i = acc; end
      step();
      id_kill_i = 0;
    end
    xif_issue_ready_i = 0; xif_issue_accept_i = 0;
    exp_id = exp_id + 1'b1;
    if (!acc) begin
      chk("illegal", illegal_o, 1);
      chk("busy_after_reject", busy_o, 0);
      chk("no_commit_on_reject", xif_commit_valid_o, 0);
      step();
      chk("illegal_one_cycle", illegal_o, 0);
      return;
    end
    chk("commit_valid", xif_commit_valid_o, 1);
    step();
    if (kill_iss) begin
      chk("idle_after_kill", id_ready_o, 1);
      return;
    end
    chk("result_ready", xif_result_ready_o, 1);
    chk("commit_one_cycle", xif_commit_valid_o, 0);
    if (kill_res) id_kill_i = 1;
    for (int k = 0; k < n_wrong; k++) begin
      xif_result_valid_i = 1; xif_result_id_i = iss ^ 4'h5;
      xif_result_rd_i = ~rd; xif_result_data_i = ~dat; xif_result_we_i = 1;
      step();
      chk("wrong_id_stays", xif_result_ready_o, 1);
    end
    xif_result_valid_i = 1; xif_result_id_i = iss;
    xif_result_rd_i = rd; xif_result_data_i = dat; xif_result_we_i = we;
    step();
    xif_result_valid_i = 0; id_kill_i = 0;
    chk("wb_valid", wb_valid_o, we);
    chk("busy_done", busy_o, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    step();
    chk("rst_id_ready", id_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_issue_valid", xif_issue_valid_o, 0);
    chk("rst_issue_id", xif_issue_id_o, 0);
    chk("rst_issue_instr", xif_issue_instr_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_wb_data", wb_data_o, 0);
    chk("rst_illegal", illegal_o, 0);
    chk("rst_timeout", timeout_o, 0);

    // Accept path with zero-wait coprocessor: 0xB, 5+7 -> rd3=12.
    run_op(32'h0000_000B, 32'd5, 32'd7, 0, 1, 0, 0, 5'd3, 32'd12, 1, 0);
    // Reject.
    run_op(32'h0000_100B, 32'd1, 32'd2, 0, 0, 0, 0, 5'd0, 32'd0, 0, 0);
    // Backpressure: five stalled cycles then handshake.
    run_op(32'h0000_202B, 32'h1111_1111, 32'h2222_2222, 5, 1, 0, 0, 5'd9, 32'hCAFE_F00D, 1, 0);
    // Kill during ISSUE (with some backpressure so the kill must stick).
    run_op(32'h0000_303B, 32'd4, 32'd4, 2, 1, 1, 0, 5'd1, 32'd8, 1, 0);
    // Kill in RESULT is ignored; one wrong-ID result first.
    run_op(32'h0000_404B, 32'd10, 32'd20, 0, 1, 0, 1, 5'd31, 32'd30, 1, 1);
    // Result with we=0: no writeback strobe.
    run_op(32'h0000_505B, 32'd6, 32'd6, 0, 1, 0, 0, 5'd2, 32'd36, 0, 0);

    // Valid and kill in the same IDLE cycle: nothing starts.
    id_valid_i = 1; id_kill_i = 1;
    step();
    id_valid_i = 0; id_kill_i = 0;
    chk("idle_kill_busy", busy_o, 0);
    chk("idle_kill_no_issue", xif_issue_valid_o, 0);

    // Reset while waiting for a result.
    cmt_q.push_back(cmt_t'{id: exp_id, kill: 1'b0});
    id_valid_i = 1; step(); id_valid_i = 0;
    xif_issue_ready_i = 1; xif_issue_accept_i = 1; step();
    xif_issue_ready_i = 0; xif_issue_accept_i = 0; step();
    chk("pre_reset_result", xif_result_ready_o, 1);
    rst_n = 0;
    #1;
    chk("reset_busy", busy_o, 0);
    chk("reset_result_ready", xif_result_ready_o, 0);
    chk("reset_issue_id", xif_issue_id_o, 0);
    chk("reset_wb_valid", wb_valid_o, 0);
    step();
    rst_n = 1;
    exp_id = '0;
    step();

    // ID wrap: 17 back-to-back accepted ops, IDs 0..15 then 0.
    for (int i = 0; i < 17; i++)
      run_op(32'h0000_000B | (i << 7), i, 2 * i, 0, 1, 0, (i % 4 == 0) ? 1 : 0,
             5'(i), 32'(3 * i + 1), 1, 0);
    chk("wrap_id_after", xif_issue_id_o, 1);

`ifdef XIF_TIMEOUT_EN
    begin
      int n;
      cmt_q.push_back(cmt_t'{id: exp_id, kill: 1'b0});
      tmo_q.push_back(1);
      id_valid_i = 1; step(); id_valid_i = 0;
      xif_issue_ready_i = 1; xif_issue_accept_i = 1; step();
      xif_issue_ready_i = 0; xif_issue_accept_i = 0; step();
      exp_id = exp_id + 1'b1;
      n = 0;
      while (!timeout_o && n < 50) begin step(); n++; end
      chk("timeout_cycles", n, 8);
      chk("timeout_idle", busy_o, 0);
      xif_result_valid_i = 1; xif_result_id_i = exp_id - 1'b1; xif_result_we_i = 1;
      step();
      xif_result_valid_i = 0;
      chk("late_result_dropped", wb_valid_o, 0);
    end
`else
    chk("timeout_tied", timeout_o, 0);
`endif

    repeat (3) step();
    chk("cmt_q_drained", cmt_q.size(), 0);
    chk("wb_q_drained", wb_q.size(), 0);
    chk("ill_q_drained", ill_q.size(), 0);
    chk("tmo_q_drained", tmo_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
